// File: rtl/ahb_error_subordinate_if.sv
// AHB-Lite subordinate-side bus bundle for ahb_error_subordinate.
interface ahb_error_subordinate_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADYin;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic [1:0]            HRESP;
  logic                  HREADYout;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYin,
    input  HRDATA, HRESP, HREADYout
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYin,
    output HRDATA, HRESP, HREADYout
  );
endinterface

// File: rtl/ahb_error_subordinate.sv
// AHB-Lite default subordinate: two-cycle ERROR or constant-read OKAY response with
// programmable wait states, plus first-fault capture, saturating count and sticky IRQ.
module ahb_error_subordinate #(
  parameter int unsigned           ADDR_WIDTH    = 32,
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter int unsigned           WAIT_STATES   = 0,
  parameter int unsigned           RESP_MODE     = 0,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_RDATA = '0,
  parameter int unsigned           CNT_WIDTH     = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb_error_subordinate_if.slave bus,
  input  logic                  ERR_CLR,
  output logic [ADDR_WIDTH-1:0] ERR_ADDR,
  output logic                  ERR_WRITE,
  output logic [2:0]            ERR_SIZE,
  output logic [CNT_WIDTH-1:0]  ERR_COUNT,
  output logic                  ERR_IRQ
);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2, ST_DONE} state_t;

  localparam logic [3:0] LP_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam state_t     LP_RESP_ST   = (RESP_MODE == 0) ? ST_ERR1 : ST_DONE;

  state_t                r_state, w_next;
  logic [3:0]            r_wait_cnt, w_wait_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_cap_addr;
  logic                  r_cap_write;
  logic [2:0]            r_cap_size;

  logic                  r_hreadyout;
  logic [1:0]            r_hresp;
  logic [DATA_WIDTH-1:0] r_hrdata;

  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic                  r_err_write;
  logic [2:0]            r_err_size;
  logic [CNT_WIDTH-1:0]  r_err_count;
  logic                  r_err_irq;

  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_in_addr;
  logic                  w_in_write;
  logic [2:0]            w_in_size;
  logic                  w_err_entry;
  logic                  w_unused;

  assign w_unused = ^{bus.HTRANS[0], bus.HBURST, bus.HWDATA};

  assign w_accept = (r_state inside {ST_IDLE, ST_ERR2, ST_DONE}) &&
                    bus.HSEL && bus.HREADYin && bus.HTRANS[1];

  // Responding straight from an accept uses the live address phase; after wait
  // states the transfer attributes come from the copy latched at accept.
  assign w_in_addr  = (r_state == ST_WAIT) ? r_cap_addr  : bus.HADDR;
  assign w_in_write = (r_state == ST_WAIT) ? r_cap_write : bus.HWRITE;
  assign w_in_size  = (r_state == ST_WAIT) ? r_cap_size  : bus.HSIZE;

  always_comb begin
    w_next         = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      ST_IDLE, ST_ERR2, ST_DONE: begin
        if (w_accept) begin
          if (WAIT_STATES > 0) begin
            w_next         = ST_WAIT;
            w_wait_cnt_nxt = LP_WAIT_LOAD;
          end else begin
            w_next = LP_RESP_ST;
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt == 4'd0) w_next = LP_RESP_ST;
        else                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
      end
      ST_ERR1: w_next = ST_ERR2;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_err_entry = (w_next == ST_ERR1);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= '0;
      r_cap_addr  <= '0;
      r_cap_write <= 1'b0;
      r_cap_size  <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 2'b00;
      r_hrdata    <= '0;
    end else begin
      r_state     <= w_next;
      r_wait_cnt  <= w_wait_cnt_nxt;
      if (w_accept) begin
        r_cap_addr  <= bus.HADDR;
        r_cap_write <= bus.HWRITE;
        r_cap_size  <= bus.HSIZE;
      end
      r_hreadyout <= !(w_next inside {ST_WAIT, ST_ERR1});
      r_hresp     <= (w_next inside {ST_ERR1, ST_ERR2}) ? 2'b01 : 2'b00;
      r_hrdata    <= (w_next == ST_DONE && !w_in_write) ? DEFAULT_RDATA : '0;
    end
  end

  // A clear coinciding with a new error counts that error as the first one.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_err_addr  <= '0;
      r_err_write <= 1'b0;
      r_err_size  <= '0;
      r_err_count <= '0;
      r_err_irq   <= 1'b0;
    end else if (w_err_entry) begin
      if (ERR_CLR || r_err_count == '0) begin
        r_err_addr  <= w_in_addr;
        r_err_write <= w_in_write;
        r_err_size  <= w_in_size;
      end
      if (ERR_CLR)          r_err_count <= CNT_WIDTH'(1);
      else if (!(&r_err_count)) r_err_count <= r_err_count + CNT_WIDTH'(1);
      r_err_irq <= 1'b1;
    end else if (ERR_CLR) begin
      r_err_addr  <= '0;
      r_err_write <= 1'b0;
      r_err_size  <= '0;
      r_err_count <= '0;
      r_err_irq   <= 1'b0;
    end
  end

  assign bus.HREADYout = r_hreadyout;
  assign bus.HRESP     = r_hresp;
  assign bus.HRDATA    = r_hrdata;
  assign ERR_ADDR      = r_err_addr;
  assign ERR_WRITE     = r_err_write;
  assign ERR_SIZE      = r_err_size;
  assign ERR_COUNT     = r_err_count;
  assign ERR_IRQ       = r_err_irq;

endmodule

// File: tb/tb_ahb_error_subordinate.sv
// Bench: three configurations driven in parallel, checked every cycle against a
// transaction-queue model, with directed literal checks and random traffic.
module tb_ahb_error_subordinate;

  localparam int unsigned P_W    [3] = '{0, 3, 1};
  localparam int unsigned P_MODE [3] = '{0, 0, 1};
  localparam logic [31:0] P_DRD  [3] = '{32'h0, 32'h0, 32'hDEADBEEF};

  typedef struct packed {
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        err1;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  sz;
  } item_t;

  logic        clk, rst;
  logic        s_hsel, s_write, s_clr;
  logic [1:0]  s_trans;
  logic [31:0] s_addr, s_wdata;
  logic [2:0]  s_size, s_burst;
  logic        s_rdy_in [3];

  logic        o_rdy   [3];
  logic [1:0]  o_resp  [3];
  logic [31:0] o_rdata [3];
  logic [31:0] o_eaddr [3];
  logic        o_ewr   [3];
  logic [2:0]  o_esz   [3];
  logic [7:0]  o_ecnt  [3];
  logic        o_eirq  [3];

  item_t       q [3][$];
  logic [31:0] m_addr [3];
  logic        m_wr   [3];
  logic [2:0]  m_sz   [3];
  int          m_cnt  [3];
  logic        m_irq  [3];

  int vectors = 0;
  int miscompares = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_error_subordinate_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u_if ();
    assign u_if.HSEL     = s_hsel;
    assign u_if.HADDR    = s_addr;
    assign u_if.HTRANS   = s_trans;
    assign u_if.HWRITE   = s_write;
    assign u_if.HSIZE    = s_size;
    assign u_if.HBURST   = s_burst;
    assign u_if.HWDATA   = s_wdata;
    assign u_if.HREADYin = s_rdy_in[g];
    assign o_rdy[g]      = u_if.HREADYout;
    assign o_resp[g]     = u_if.HRESP;
    assign o_rdata[g]    = u_if.HRDATA;

    ahb_error_subordinate #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(P_W[g]),
      .RESP_MODE(P_MODE[g]), .DEFAULT_RDATA(P_DRD[g]), .CNT_WIDTH(8)
    ) u_dut (
      .HCLK(clk), .HRESET(rst), .bus(u_if.slave), .ERR_CLR(s_clr),
      .ERR_ADDR(o_eaddr[g]), .ERR_WRITE(o_ewr[g]), .ERR_SIZE(o_esz[g]),
      .ERR_COUNT(o_ecnt[g]), .ERR_IRQ(o_eirq[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic item_t mk(input logic rdy, input logic [1:0] resp, input logic [31:0] rdata,
                               input logic err1, input logic [31:0] a, input logic wr,
                               input logic [2:0] sz);
    item_t it;
    it.rdy = rdy; it.resp = resp; it.rdata = rdata; it.err1 = err1;
    it.addr = a; it.wr = wr; it.sz = sz;
    return it;
  endfunction

  function automatic item_t cur_item(input int k);
    if (q[k].size() != 0) return q[k][0];
    return mk(1'b1, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 3'h0);
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      q[k].delete();
      m_addr[k] = '0; m_wr[k] = 1'b0; m_sz[k] = '0; m_cnt[k] = 0; m_irq[k] = 1'b0;
    end
  endtask

  task automatic check_all();
    item_t it;
    for (int k = 0; k < 3; k++) begin
      it = cur_item(k);
      chk("hreadyout", k, 32'(o_rdy[k]),  32'(it.rdy));
      chk("hresp",     k, 32'(o_resp[k]), 32'(it.resp));
      chk("hrdata",    k, o_rdata[k],     it.rdata);
      chk("err_addr",  k, o_eaddr[k],     m_addr[k]);
      chk("err_write", k, 32'(o_ewr[k]),  32'(m_wr[k]));
      chk("err_size",  k, 32'(o_esz[k]),  32'(m_sz[k]));
      chk("err_count", k, 32'(o_ecnt[k]), 32'(m_cnt[k]));
      chk("err_irq",   k, 32'(o_eirq[k]), 32'(m_irq[k]));
    end
  endtask

  // One bus cycle: drive inputs, advance the model across the edge, compare.
  task automatic step(input logic hsel, input logic [1:0] tr, input logic [31:0] a,
                      input logic wr, input logic [2:0] sz, input logic mask, input logic clr);
    item_t it;
    logic  acc;
    s_hsel = hsel; s_trans = tr; s_addr = a; s_write = wr; s_size = sz; s_clr = clr;
    s_burst = 3'($urandom); s_wdata = $urandom;
    for (int k = 0; k < 3; k++) s_rdy_in[k] = cur_item(k).rdy & mask;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      acc = hsel && s_rdy_in[k] && tr[1];
      if (q[k].size() != 0) void'(q[k].pop_front());
      if (acc) begin
        for (int unsigned w = 0; w < P_W[k]; w++)
          q[k].push_back(mk(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 3'h0));
        if (P_MODE[k] == 0) begin
          q[k].push_back(mk(1'b0, 2'b01, 32'h0, 1'b1, a, wr, sz));
          q[k].push_back(mk(1'b1, 2'b01, 32'h0, 1'b0, 32'h0, 1'b0, 3'h0));
        end else begin
          q[k].push_back(mk(1'b1, 2'b00, wr ? 32'h0 : P_DRD[k], 1'b0, 32'h0, 1'b0, 3'h0));
        end
      end
      it = cur_item(k);
      if (it.err1) begin
        if (clr || m_cnt[k] == 0) begin
          m_addr[k] = it.addr; m_wr[k] = it.wr; m_sz[k] = it.sz;
        end
        m_cnt[k] = clr ? 1 : ((m_cnt[k] < 255) ? m_cnt[k] + 1 : 255);
        m_irq[k] = 1'b1;
      end else if (clr) begin
        m_addr[k] = '0; m_wr[k] = 1'b0; m_sz[k] = '0; m_cnt[k] = 0; m_irq[k] = 1'b0;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 2'b00, $urandom, 1'b0, 3'h0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    s_hsel = 0; s_trans = 0; s_addr = 0; s_write = 0; s_size = 0; s_burst = 0; s_wdata = 0; s_clr = 0;
    for (int k = 0; k < 3; k++) s_rdy_in[k] = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_hready", k, 32'(o_rdy[k]), 32'h1);
      chk("rst_hresp",  k, 32'(o_resp[k]), 32'h0);
      chk("rst_count",  k, 32'(o_ecnt[k]), 32'h0);
    end
    rst = 1'b0;

    idle(3);

    // Read at 0x1234 seen by all three configurations
    step(1'b1, 2'b10, 32'h0000_1234, 1'b0, 3'b010, 1'b1, 1'b0);
    chk("t1_c1_rdy", 0, 32'(o_rdy[0]), 32'h0);
    chk("t1_c1_resp", 0, 32'(o_resp[0]), 32'h1);
    chk("t1_w3_rdy", 1, 32'(o_rdy[1]), 32'h0);
    chk("t1_w3_resp", 1, 32'(o_resp[1]), 32'h0);
    idle(1);
    chk("t1_c2_rdy", 0, 32'(o_rdy[0]), 32'h1);
    chk("t1_c2_resp", 0, 32'(o_resp[0]), 32'h1);
    chk("t1_eaddr", 0, o_eaddr[0], 32'h0000_1234);
    chk("t1_ewr", 0, 32'(o_ewr[0]), 32'h0);
    chk("t1_ecnt", 0, 32'(o_ecnt[0]), 32'h1);
    chk("t1_eirq", 0, 32'(o_eirq[0]), 32'h1);
    chk("t1_m1_rdata", 2, o_rdata[2], 32'hDEADBEEF);
    chk("t1_m1_resp", 2, 32'(o_resp[2]), 32'h0);
    chk("t1_m1_ecnt", 2, 32'(o_ecnt[2]), 32'h0);
    idle(2);
    chk("t1_w3_err1", 1, 32'(o_resp[1]), 32'h1);
    chk("t1_w3_esz", 1, 32'(o_esz[1]), 32'h2);
    idle(2);

    // Write: mode-1 returns zero data
    step(1'b1, 2'b10, 32'h0000_0020, 1'b1, 3'b010, 1'b1, 1'b0);
    idle(1);
    chk("t2_m1_rdata", 2, o_rdata[2], 32'h0);
    chk("t2_m1_rdy", 2, 32'(o_rdy[2]), 32'h1);
    idle(2);
    chk("t2_w3_ecnt", 1, 32'(o_ecnt[1]), 32'h2);
    chk("t2_w3_eaddr", 1, o_eaddr[1], 32'h0000_1234);
    idle(3);

    // Clear, then back-to-back errors
    step(1'b1, 2'b00, 32'h0, 1'b0, 3'h0, 1'b1, 1'b1);
    chk("t3_clr_cnt", 0, 32'(o_ecnt[0]), 32'h0);
    chk("t3_clr_irq", 0, 32'(o_eirq[0]), 32'h0);
    step(1'b1, 2'b10, 32'h10, 1'b0, 3'h0, 1'b1, 1'b0);
    step(1'b1, 2'b10, 32'h20, 1'b0, 3'h0, 1'b1, 1'b0);
    step(1'b1, 2'b10, 32'h20, 1'b0, 3'h0, 1'b1, 1'b0);
    chk("t3_b2b_rdy", 0, 32'(o_rdy[0]), 32'h0);
    chk("t3_b2b_resp", 0, 32'(o_resp[0]), 32'h1);
    chk("t3_b2b_cnt", 0, 32'(o_ecnt[0]), 32'h2);
    chk("t3_b2b_addr", 0, o_eaddr[0], 32'h10);
    idle(6);

    // Saturation
    for (int i = 0; i < 700; i++)
      step(1'b1, 2'b10, $urandom, 1'($urandom), 3'($urandom), 1'b1, 1'b0);
    chk("t4_sat", 0, 32'(o_ecnt[0]), 32'd255);
    idle(6);

    // Clear coincident with ERR1 entry
    step(1'b1, 2'b10, 32'h40, 1'b1, 3'b001, 1'b1, 1'b1);
    chk("t5_cnt", 0, 32'(o_ecnt[0]), 32'h1);
    chk("t5_irq", 0, 32'(o_eirq[0]), 32'h1);
    chk("t5_addr", 0, o_eaddr[0], 32'h40);
    chk("t5_wr", 0, 32'(o_ewr[0]), 32'h1);
    chk("t5_w3_cnt", 1, 32'(o_ecnt[1]), 32'h0);
    idle(6);

    // Asynchronous reset during ERR1
    step(1'b1, 2'b10, 32'h80, 1'b0, 3'h0, 1'b1, 1'b0);
    chk("t6_pre_resp", 0, 32'(o_resp[0]), 32'h1);
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("t6_rdy", k, 32'(o_rdy[k]), 32'h1);
      chk("t6_resp", k, 32'(o_resp[k]), 32'h0);
      chk("t6_rdata", k, o_rdata[k], 32'h0);
      chk("t6_cnt", k, 32'(o_ecnt[k]), 32'h0);
      chk("t6_irq", k, 32'(o_eirq[k]), 32'h0);
      chk("t6_addr", k, o_eaddr[k], 32'h0);
    end
    model_reset();
    #1 rst = 1'b0;
    idle(2);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, 2'($urandom), $urandom, 1'($urandom), 3'($urandom),
           $urandom_range(0, 7) != 0, $urandom_range(0, 31) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_error_subordinate.md
# ahb_error_subordinate

Parametrised AHB-Lite default/error subordinate for the interconnect's unmapped address space, replacing the fixed single-mode default subordinate. It drives the protocol-correct two-cycle ERROR response, or a configurable read-as-constant/write-ignored OKAY response, with programmable wait states. It also captures the first faulting transfer and keeps a saturating error count with a sticky interrupt for system diagnostics.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HWDATA/HRDATA width
- WAIT_STATES, 0, HREADYout-low cycles inserted before the response (0..15)
- RESP_MODE, 0, 0 = ERROR response; 1 = OKAY, reads return DEFAULT_RDATA, writes discarded
- DEFAULT_RDATA, 0, HRDATA value in RESP_MODE 1
- CNT_WIDTH, 8, width of ERR_COUNT
- HCLK  in  1  clock, all logic on rising edge
- HRESET  in  1  asynchronous, active-high reset
- HSEL  in  1  subordinate select
- HADDR  in  ADDR_WIDTH  address
- HTRANS  in  2  transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size
- HBURST  in  3  burst type (ignored)
- HWDATA  in  DATA_WIDTH  write data (ignored)
- HREADYin  in  1  bus HREADY
- HRDATA  out  DATA_WIDTH  read data
- HRESP  out  2  00 OKAY, 01 ERROR
- HREADYout  out  1  transfer done
- ERR_CLR  in  1  one-cycle pulse: clear capture, count, IRQ
- ERR_ADDR  out  ADDR_WIDTH  HADDR of first ERROR since clear
- ERR_WRITE  out  1  HWRITE of that transfer
- ERR_SIZE  out  3  HSIZE of that transfer
- ERR_COUNT  out  CNT_WIDTH  ERROR responses since clear, saturates at all-ones
- ERR_IRQ  out  1  sticky, set by any ERROR response

## Operation
- Accept (address phase) at a rising edge when HSEL & HREADYin & HTRANS[1]. HSEL with IDLE/BUSY, or HREADYin low, is not accepted; data phase then is OKAY, zero-wait.
- States: IDLE, WAIT, ERR1, ERR2, DONE. All outputs registered from state.
- IDLE: HREADYout=1, HRESP=00. On accept: WAIT_STATES>0 -> WAIT (counter loaded WAIT_STATES-1); else mode 0 -> ERR1, mode 1 -> DONE.
- WAIT: HREADYout=0, HRESP=00; counter decrements; at 0 -> ERR1 (mode 0) or DONE (mode 1).
- ERR1: HREADYout=0, HRESP=01; always -> ERR2.
- ERR2: HREADYout=1, HRESP=01. DONE: HREADYout=1, HRESP=00, HRDATA=DEFAULT_RDATA if captured HWRITE=0 else 0.
- From ERR2/DONE: new accept (HREADYin is high this cycle) -> WAIT/ERR1/DONE as from IDLE (back-to-back); otherwise -> IDLE.
- HRDATA = 0 in all states except read DONE.
- Capture: address-phase HADDR/HWRITE/HSIZE latched internally on accept; on entry to ERR1, if ERR_COUNT==0 load ERR_ADDR/WRITE/SIZE, increment ERR_COUNT (saturating), set ERR_IRQ.
- ERR_CLR with simultaneous ERR1 entry: new error wins — ERR_COUNT=1, fields loaded, ERR_IRQ=1.
- RESP_MODE 1 never touches capture, count or IRQ.

## Timing
- Reset (HRESET high, asynchronous): state IDLE, HREADYout=1, HRESP=00, HRDATA=0, ERR_ADDR=0, ERR_WRITE=0, ERR_SIZE=0, ERR_COUNT=0, ERR_IRQ=0, wait counter 0.
- Reset mid-transfer: outputs go to reset values immediately; no partial ERROR completes.
- Accept at edge E: mode 0 with W wait states -> HREADYout low for W+1 cycles after E (W OKAY, then ERR1), ERR2 on cycle W+2; total data phase W+2 cycles. Mode 1 -> data phase W+1 cycles.
- ERR_COUNT/ERR_IRQ/ERR_ADDR update at the edge entering ERR1 (visible during ERR1).

## Test plan
- Reset, idle bus, HSEL=1 HTRANS=IDLE -> HREADYout=1, HRESP=00 every cycle, ERR_COUNT=0.
- WAIT_STATES=0, mode 0, NONSEQ read at 0x0000_1234 -> cycle+1: HREADYout=0 HRESP=01; cycle+2: HREADYout=1 HRESP=01; ERR_ADDR=0x1234, ERR_WRITE=0, ERR_COUNT=1, ERR_IRQ=1.
- WAIT_STATES=3, mode 0, write HSIZE=010 -> 3 cycles HREADYout=0 HRESP=00, then ERR1, ERR2; ERR_SIZE=010.
- Back-to-back NONSEQ at 0x10 then 0x20 (second accepted in ERR2) -> two full ERROR pairs, no IDLE gap, ERR_ADDR=0x10, ERR_COUNT=2; 300 errors with CNT_WIDTH=8 -> ERR_COUNT=255.
- Mode 1, DEFAULT_RDATA=0xDEADBEEF, WAIT_STATES=1, read -> one wait cycle, then HREADYout=1 HRESP=00 HRDATA=0xDEADBEEF; write -> HRDATA=0; ERR_COUNT stays 0.
- ERR_CLR pulse coincident with ERR1 entry -> ERR_COUNT=1, ERR_IRQ=1; HRESET asserted during ERR1 -> HREADYout=1, HRESP=00 without waiting for an edge.
